// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, W-stage status values and special register indices.
package y86_pkg;

    typedef enum logic [3:0] {
        IHalt   = 4'h0,
        INop    = 4'h1,
        ICmovxx = 4'h2,
        IIrmovq = 4'h3,
        IRmmovq = 4'h4,
        IMrmovq = 4'h5,
        IOpq    = 4'h6,
        IJxx    = 4'h7,
        ICall   = 4'h8,
        IRet    = 4'h9,
        IPushq  = 4'hA,
        IPopq   = 4'hB
    } icode_e;

    typedef enum logic [2:0] {
        StatBub = 3'd0,
        StatAok = 3'd1,
        StatHlt = 3'd2,
        StatAdr = 3'd3,
        StatIns = 3'd4
    } stat_e;

    localparam int unsigned RNONE_IDX = 15;
    localparam int unsigned RSP_IDX   = 4;

    // Undefined status encodings (5..7) collapse onto INS.
    function automatic logic [2:0] norm_stat(input logic [2:0] s);
        return (s > StatIns) ? StatIns : s;
    endfunction

endpackage

// File: rtl/y86_regfile_wb_if.sv
// W-stage commit bus, decode read ports and architectural status exported by the write-back block.
interface y86_regfile_wb_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned NREGS  = 15,
    parameter int unsigned RCNT_W = 32
);
    logic [2:0]              w_stat;
    logic [3:0]              w_icode;
    logic [3:0]              w_ifun;
    logic                    w_cnd;
    logic [3:0]              w_dstE;
    logic [3:0]              w_dstM;
    logic [DATA_W-1:0]       w_valE;
    logic [DATA_W-1:0]       w_valM;
    logic [3:0]              d_srcA;
    logic [3:0]              d_srcB;
    logic [DATA_W-1:0]       d_rvalA;
    logic [DATA_W-1:0]       d_rvalB;
    logic                    halted;
    logic [2:0]              stat_out;
    logic [RCNT_W-1:0]       retired_cnt;
    logic [NREGS*DATA_W-1:0] rf_flat;

    modport master (
        output w_stat, w_icode, w_ifun, w_cnd, w_dstE, w_dstM, w_valE, w_valM, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB, halted, stat_out, retired_cnt, rf_flat
    );

    modport slave (
        input  w_stat, w_icode, w_ifun, w_cnd, w_dstE, w_dstM, w_valE, w_valM, d_srcA, d_srcB,
        output d_rvalA, d_rvalB, halted, stat_out, retired_cnt, rf_flat
    );

endinterface

// File: rtl/y86_rf_core.sv
// Register storage with two write ports (M beats E on the same index) and two bypassed read ports.
module y86_rf_core #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NREGS     = 15,
    parameter bit          RESET_IDX = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we_e_i,
    input  logic [3:0]              waddr_e_i,
    input  logic [DATA_W-1:0]       wdata_e_i,
    input  logic                    we_m_i,
    input  logic [3:0]              waddr_m_i,
    input  logic [DATA_W-1:0]       wdata_m_i,
    input  logic [3:0]              raddr_a_i,
    input  logic [3:0]              raddr_b_i,
    output logic [DATA_W-1:0]       rdata_a_o,
    output logic [DATA_W-1:0]       rdata_b_o,
    output logic [NREGS*DATA_W-1:0] rf_flat_o
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Enables are only raised for in-range indices, so the writes never index past NREGS.
    always_comb begin
        regs_d = regs_q;
        if (we_e_i) begin
            regs_d[waddr_e_i] = wdata_e_i;
        end
        if (we_m_i) begin
            regs_d[waddr_m_i] = wdata_m_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= RESET_IDX ? DATA_W'(i) : '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
        logic [DATA_W-1:0] val;
        val = '0;
        if (32'(addr) < NREGS) begin
            if (we_m_i && (addr == waddr_m_i)) begin
                val = wdata_m_i;
            end else if (we_e_i && (addr == waddr_e_i)) begin
                val = wdata_e_i;
            end else begin
                val = regs_q[addr];
            end
        end
        return val;
    endfunction

    always_comb begin
        rdata_a_o = read_port(raddr_a_i);
        rdata_b_o = read_port(raddr_b_i);
    end

    for (genvar g = 0; g < int'(NREGS); g++) begin : gen_flat
        assign rf_flat_o[g*DATA_W +: DATA_W] = regs_q[g];
    end

endmodule

// File: rtl/y86_regfile_wb.sv
// Y86-64 write-back stage: commit gating, sticky halt latch and retired-instruction counter
// wrapped around the architectural register file.
module y86_regfile_wb
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned NREGS     = 15,
    parameter int unsigned RNONE     = 15,
    parameter bit          RESET_IDX = 1'b1,
    parameter int unsigned RCNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    y86_regfile_wb_if.slave  bus
);

    logic              commit;
    logic              cmov_skip;
    logic              dst_e_ok;
    logic              dst_m_ok;
    logic              we_e;
    logic              we_m;
    logic              stop;

    logic              halted_q, halted_d;
    logic [2:0]        stat_q, stat_d;
    logic [RCNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        commit    = !halted_q && (bus.w_stat == StatAok);
        // A conditional move whose condition failed retires without writing.
        cmov_skip = (bus.w_icode == ICmovxx) && (bus.w_ifun != 4'd0) && !bus.w_cnd;
        dst_e_ok  = (32'(bus.w_dstE) < NREGS) && (32'(bus.w_dstE) != RNONE);
        dst_m_ok  = (32'(bus.w_dstM) < NREGS) && (32'(bus.w_dstM) != RNONE);
        we_e      = commit && dst_e_ok && !cmov_skip;
        we_m      = commit && dst_m_ok;
        stop      = !halted_q && (bus.w_stat != StatBub) && (bus.w_stat != StatAok);
    end

    always_comb begin
        halted_d = halted_q;
        stat_d   = stat_q;
        cnt_d    = cnt_q;
        if (stop) begin
            halted_d = 1'b1;
            stat_d   = norm_stat(bus.w_stat);
        end
        if (commit) begin
            cnt_d = cnt_q + RCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
            stat_q   <= StatAok;
            cnt_q    <= '0;
        end else begin
            halted_q <= halted_d;
            stat_q   <= stat_d;
            cnt_q    <= cnt_d;
        end
    end

    y86_rf_core #(
        .DATA_W    (DATA_W),
        .NREGS     (NREGS),
        .RESET_IDX (RESET_IDX)
    ) u_rf_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .we_e_i    (we_e),
        .waddr_e_i (bus.w_dstE),
        .wdata_e_i (bus.w_valE),
        .we_m_i    (we_m),
        .waddr_m_i (bus.w_dstM),
        .wdata_m_i (bus.w_valM),
        .raddr_a_i (bus.d_srcA),
        .raddr_b_i (bus.d_srcB),
        .rdata_a_o (bus.d_rvalA),
        .rdata_b_o (bus.d_rvalB),
        .rf_flat_o (bus.rf_flat)
    );

    assign bus.halted      = halted_q;
    assign bus.stat_out    = stat_q;
    assign bus.retired_cnt = cnt_q;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Scoreboard bench for y86_regfile_wb: a behavioural register-file model queues expected values
// per transaction, which are popped and compared against the DUT outputs.
module tb_y86_regfile_wb;

    localparam int unsigned DW = 64;
    localparam int unsigned NR = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    y86_regfile_wb_if #(.DATA_W(DW), .NREGS(NR), .RCNT_W(32)) bus   ();
    y86_regfile_wb_if #(.DATA_W(DW), .NREGS(NR), .RCNT_W(4))  bus_w ();

    y86_regfile_wb #(
        .DATA_W(DW), .NREGS(NR), .RNONE(15), .RESET_IDX(1'b1), .RCNT_W(32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    y86_regfile_wb #(
        .DATA_W(DW), .NREGS(NR), .RNONE(15), .RESET_IDX(1'b0), .RCNT_W(4)
    ) u_dut_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_w.slave)
    );

    typedef struct {
        string       tag;
        logic [63:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    logic [63:0] m_rf [NR];
    logic        m_halted;
    logic [2:0]  m_stat;
    logic [31:0] m_cnt;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [63:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [63:0] got);
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("scoreboard_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq(e.tag, got, e.exp);
        end
    endtask

    function automatic logic [63:0] rf_slice(input int idx);
        return bus.rf_flat[idx*DW +: DW];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < int'(NR); i++) m_rf[i] = 64'(i);
        m_halted = 1'b0;
        m_stat   = 3'd1;
        m_cnt    = 32'd0;
    endtask

    function automatic logic m_commit();
        return !m_halted && (bus.w_stat == 3'd1);
    endfunction

    function automatic logic m_we_e();
        return m_commit() && (bus.w_dstE < 4'd15)
               && !((bus.w_icode == 4'd2) && (bus.w_ifun != 4'd0) && !bus.w_cnd);
    endfunction

    function automatic logic m_we_m();
        return m_commit() && (bus.w_dstM < 4'd15);
    endfunction

    function automatic logic [63:0] m_read(input logic [3:0] src);
        if (src >= 4'd15) return 64'd0;
        if (m_we_m() && (src == bus.w_dstM)) return bus.w_valM;
        if (m_we_e() && (src == bus.w_dstE)) return bus.w_valE;
        return m_rf[src];
    endfunction

    task automatic m_edge();
        if (m_we_e()) m_rf[bus.w_dstE] = bus.w_valE;
        if (m_we_m()) m_rf[bus.w_dstM] = bus.w_valM;
        if (m_commit()) begin
            m_cnt = m_cnt + 32'd1;
        end else if (!m_halted && (bus.w_stat != 3'd0)) begin
            m_halted = 1'b1;
            m_stat   = (bus.w_stat > 3'd4) ? 3'd4 : bus.w_stat;
        end
    endtask

    task automatic drive(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                         input logic cnd, input logic [3:0] dst_e, input logic [3:0] dst_m,
                         input logic [63:0] val_e, input logic [63:0] val_m,
                         input logic [3:0] src_a, input logic [3:0] src_b);
        bus.w_stat  = stat;
        bus.w_icode = icode;
        bus.w_ifun  = ifun;
        bus.w_cnd   = cnd;
        bus.w_dstE  = dst_e;
        bus.w_dstM  = dst_m;
        bus.w_valE  = val_e;
        bus.w_valM  = val_m;
        bus.d_srcA  = src_a;
        bus.d_srcB  = src_b;
    endtask

    task automatic drive_bubble();
        drive(3'd0, 4'd1, 4'd0, 1'b0, 4'd15, 4'd15, 64'd0, 64'd0, 4'd15, 4'd15);
    endtask

    task automatic check_state();
        for (int i = 0; i < int'(NR); i++) push_exp($sformatf("reg%0d", i), m_rf[i]);
        push_exp("halted", 64'(m_halted));
        push_exp("stat_out", 64'(m_stat));
        push_exp("retired_cnt", 64'(m_cnt));
        for (int i = 0; i < int'(NR); i++) pop_check(rf_slice(i));
        pop_check(64'(bus.halted));
        pop_check(64'(bus.stat_out));
        pop_check(64'(bus.retired_cnt));
    endtask

    // One W-stage transaction: bypassed reads checked before the edge, full state after it.
    task automatic step(input logic [2:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                        input logic cnd, input logic [3:0] dst_e, input logic [3:0] dst_m,
                        input logic [63:0] val_e, input logic [63:0] val_m,
                        input logic [3:0] src_a, input logic [3:0] src_b);
        @(negedge clk);
        drive(stat, icode, ifun, cnd, dst_e, dst_m, val_e, val_m, src_a, src_b);
        push_exp("rvalA", m_read(src_a));
        push_exp("rvalB", m_read(src_b));
        #1;
        pop_check(bus.d_rvalA);
        pop_check(bus.d_rvalB);
        @(posedge clk);
        m_edge();
        #1;
        drive_bubble();
        #1;
        check_state();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_bubble();
        bus_w.w_stat = 3'd0; bus_w.w_icode = 4'd1; bus_w.w_ifun = 4'd0; bus_w.w_cnd = 1'b0;
        bus_w.w_dstE = 4'd15; bus_w.w_dstM = 4'd15; bus_w.w_valE = '0; bus_w.w_valM = '0;
        bus_w.d_srcA = 4'd15; bus_w.d_srcB = 4'd15;
        m_reset();
        #12;

        // Reset image, checked against fixed values.
        for (int i = 0; i < int'(NR); i++) check_eq($sformatf("rst_reg%0d", i), rf_slice(i), 64'(i));
        check_eq("rst_halted", 64'(bus.halted), 64'd0);
        check_eq("rst_stat", 64'(bus.stat_out), 64'd1);
        check_eq("rst_cnt", 64'(bus.retired_cnt), 64'd0);
        check_eq("rst_zero_pattern", bus_w.rf_flat[3*DW +: DW], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // irmovq with same-cycle read of the destination.
        step(3'd1, 4'd3, 4'd0, 1'b0, 4'd3, 4'd15, 64'hDEAD, 64'd0, 4'd3, 4'd15);
        check_eq("irmovq_reg3", rf_slice(3), 64'hDEAD);
        check_eq("irmovq_cnt", 64'(bus.retired_cnt), 64'd1);

        // cmovxx, condition false then true; rrmovq (ifun 0) always writes.
        step(3'd1, 4'd2, 4'd2, 1'b0, 4'd5, 4'd15, 64'h77, 64'd0, 4'd5, 4'd15);
        check_eq("cmov_nc_reg5", rf_slice(5), 64'd5);
        check_eq("cmov_nc_cnt", 64'(bus.retired_cnt), 64'd2);
        step(3'd1, 4'd2, 4'd2, 1'b1, 4'd5, 4'd15, 64'd7, 64'd0, 4'd15, 4'd5);
        check_eq("cmov_c_reg5", rf_slice(5), 64'd7);
        step(3'd1, 4'd2, 4'd0, 1'b0, 4'd6, 4'd15, 64'h66, 64'd0, 4'd6, 4'd6);
        check_eq("rrmovq_reg6", rf_slice(6), 64'h66);

        // popq %rsp: M port wins the collision, including on the bypass.
        step(3'd1, 4'd11, 4'd0, 1'b0, 4'd4, 4'd4, 64'h108, 64'h55, 4'd15, 4'd4);
        check_eq("popq_reg4", rf_slice(4), 64'h55);
        // Distinct E/M destinations, each bypassed to its own read port.
        step(3'd1, 4'd11, 4'd0, 1'b0, 4'd4, 4'd10, 64'h110, 64'hAA, 4'd4, 4'd10);
        step(3'd1, 4'd5, 4'd0, 1'b0, 4'd15, 4'd7, 64'd0, 64'h777, 4'd7, 4'd14);

        // Bubble: no write, no count.
        step(3'd0, 4'd6, 4'd0, 1'b0, 4'd8, 4'd9, 64'h1, 64'h2, 4'd8, 4'd9);
        check_eq("bubble_cnt", 64'(bus.retired_cnt), 64'd7);

        // ADR halts without writing; later AOK is frozen.
        step(3'd3, 4'd6, 4'd0, 1'b0, 4'd2, 4'd15, 64'd9, 64'd0, 4'd2, 4'd15);
        check_eq("adr_reg2", rf_slice(2), 64'd2);
        check_eq("adr_halted", 64'(bus.halted), 64'd1);
        check_eq("adr_stat", 64'(bus.stat_out), 64'd3);
        step(3'd1, 4'd6, 4'd0, 1'b0, 4'd2, 4'd15, 64'h1234, 64'd0, 4'd2, 4'd15);
        check_eq("frozen_reg2", rf_slice(2), 64'd2);
        check_eq("frozen_cnt", 64'(bus.retired_cnt), 64'd7);

        // Asynchronous reset while a write is presented.
        @(negedge clk);
        drive(3'd1, 4'd3, 4'd0, 1'b0, 4'd8, 4'd15, 64'hBAD, 64'd0, 4'd15, 4'd15);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_eq("midrst_reg8", rf_slice(8), 64'd8);
        check_eq("midrst_reg3", rf_slice(3), 64'd3);
        check_eq("midrst_halted", 64'(bus.halted), 64'd0);
        check_eq("midrst_cnt", 64'(bus.retired_cnt), 64'd0);
        @(posedge clk);
        #1;
        check_eq("midrst_edge_reg8", rf_slice(8), 64'd8);
        drive_bubble();
        @(negedge clk);
        rst_n = 1'b1;
        check_state();

        // Undefined status 7 is reported as INS.
        step(3'd7, 4'd3, 4'd0, 1'b0, 4'd1, 4'd15, 64'h99, 64'd0, 4'd1, 4'd15);
        check_eq("ins_stat", 64'(bus.stat_out), 64'd4);

        // Counter wrap on the 4-bit instance.
        @(negedge clk);
        bus_w.w_stat = 3'd1;
        repeat (15) @(posedge clk);
        #1;
        check_eq("wrap_cnt15", 64'(bus_w.retired_cnt), 64'd15);
        @(posedge clk);
        #1;
        bus_w.w_stat = 3'd0;
        check_eq("wrap_cnt0", 64'(bus_w.retired_cnt), 64'd0);
        check_eq("wrap_halted", 64'(bus_w.halted), 64'd0);

        check_eq("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
